// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, one-hot FSM encoding, control-bus bit indices and decode record
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JMI = 4'd5;
  localparam logic [3:0] OP_JEQ = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;
  localparam logic [3:0] OP_LDA = 4'd8;

  localparam int DC_ACC_LOAD = 0;
  localparam int DC_MUX3     = 1;
  localparam int DC_ALU      = 2;

  localparam int JF_SKIP   = 0;
  localparam int JF_MI     = 1;
  localparam int JF_EQ_BAR = 2;

  typedef enum logic [2:0] {
    S_HALT  = 3'b000,
    S_FETCH = 3'b001,
    S_EXEC1 = 3'b010,
    S_EXEC2 = 3'b100
  } state_e;

  typedef struct packed {
    logic ldi;
    logic sta;
    logic add;
    logic sub;
    logic jmp;
    logic jmi;
    logic jeq;
    logic stp;
    logic lda;
    logic ill;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decode and branch-taken evaluation
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] inst,
  input  logic [2:0]       jmp_flags,
  output dec_t             dec,
  output logic             taken
);

  logic       ill;
  logic [3:0] op;

  // any set bit above the 4-bit opcode field makes the instruction a NOP flagged as illegal
  always_comb begin
    ill       = (inst >> 4) != '0;
    op        = inst[3:0];
    dec       = '0;
    dec.ill   = ill;
    dec.ldi   = !ill && op == OP_LDI;
    dec.sta   = !ill && op == OP_STA;
    dec.add   = !ill && op == OP_ADD;
    dec.sub   = !ill && op == OP_SUB;
    dec.jmp   = !ill && op == OP_JMP;
    dec.jmi   = !ill && op == OP_JMI;
    dec.jeq   = !ill && op == OP_JEQ;
    dec.stp   = !ill && op == OP_STP;
    dec.lda   = !ill && op == OP_LDA;
    taken     = dec.jmp | (dec.jmi & jmp_flags[JF_MI]) | (dec.jeq & ~jmp_flags[JF_EQ_BAR]);
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: FETCH/EXEC1/EXEC2/HALT control FSM with retire counter; CTRL_SEQ_WAIT_EN adds mem_ready stalls
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] inst,
  input  logic [2:0]       jmp_flags,
  input  logic             mem_ready,
  input  logic             run,
  output logic [2:0]       data_ctrl,
  output logic             e,
  output logic             mux1,
  output logic             wr_en,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             p,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  dec_t             dec;
  logic             taken;
  logic             mem_ok;
  logic             retire;
  logic             fet, ex1, ex2, stall;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .inst      (inst),
    .jmp_flags (jmp_flags),
    .dec       (dec),
    .taken     (taken)
  );

`ifdef CTRL_SEQ_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = mem_ready | 1'b1;
`endif

  // next state, retire event and sticky illegal flag
  always_comb begin
    unique case (state_q)
      S_FETCH: state_d = mem_ok ? S_EXEC1 : S_FETCH;
      S_EXEC1: state_d = (dec.lda | dec.add | dec.sub) ? S_EXEC2 : dec.stp ? S_HALT : S_FETCH;
      S_EXEC2: state_d = mem_ok ? S_FETCH : S_EXEC2;
      default: state_d = run ? S_FETCH : S_HALT;
    endcase
    retire    = (state_q == S_EXEC1 && state_d != S_EXEC2) || (state_q == S_EXEC2 && mem_ok);
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    illegal_d = illegal_q | (state_q == S_EXEC1 && dec.ill);
  end

  // state, counter and sticky flag registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // datapath strobes from the current state; all forced low while reset is asserted
  always_comb begin
    fet       = rst_n && state_q == S_FETCH;
    ex1       = rst_n && state_q == S_EXEC1;
    ex2       = rst_n && state_q == S_EXEC2;
    stall     = ~mem_ok & (fet | ex2);
    p         = (ex1 | ex2) & (dec.lda | dec.ldi | dec.jmp | dec.jmi | dec.jeq);
    e         = (ex1 | ex2) & (dec.lda | dec.add | dec.sub);
    mux1      = (ex1 & (dec.lda | taken)) | ((ex1 | ex2) & (dec.sta | dec.add | dec.sub));
    wr_en     = ex1 & dec.sta & ~stall;
    pc_load   = ((ex1 & taken) | (fet & jmp_flags[JF_SKIP])) & ~stall;
    pc_inc    = ex1 & ~dec.stp & ~taken & ~stall;
    data_ctrl = '0;
    data_ctrl[DC_ALU]      = (ex1 | ex2) & dec.add;
    data_ctrl[DC_MUX3]     = (ex1 | ex2) & (dec.add | dec.sub);
    data_ctrl[DC_ACC_LOAD] = ((ex1 & dec.ldi) | (ex2 & (dec.lda | dec.add | dec.sub))) & ~stall;
  end

  assign state   = state_q;
  assign halted  = state_q == S_HALT;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed vectors with a queued scoreboard checked by an independent monitor
module tb_ctrl_sequencer;

  localparam int OPC_W = 6;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [OPC_W-1:0] inst;
  logic [2:0]       jmp_flags;
  logic             mem_ready;
  logic             run;
  logic [2:0]       data_ctrl;
  logic             e, mux1, wr_en, pc_load, pc_inc, p;
  logic [2:0]       state;
  logic             halted, illegal;
  logic [CNT_W-1:0] retired;
  logic [17:0]      act;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  ctrl_sequencer #(.OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .jmp_flags (jmp_flags),
    .mem_ready (mem_ready),
    .run       (run),
    .data_ctrl (data_ctrl),
    .e         (e),
    .mux1      (mux1),
    .wr_en     (wr_en),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .p         (p),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  assign act = {state, data_ctrl, e, mux1, wr_en, pc_load, pc_inc, p, halted, illegal, retired};

  // sb packs {e, mux1, wr_en, pc_load, pc_inc, p}
  task automatic step(input string nm, input int in, input int fl, input int mr, input int rn,
                      input int st, input int dc, input int sb, input int h, input int il, input int rt);
    exp_t x;
    inst      = OPC_W'(in);
    jmp_flags = 3'(fl);
    mem_ready = 1'(mr);
    run       = 1'(rn);
    x.name    = nm;
    x.v       = {3'(st), 3'(dc), 6'(sb), 1'(h), 1'(il), 4'(rt)};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  exp_t mx;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      total++;
      if (act !== mx.v) begin
        bad++;
        $display("FAIL %s got=%b want=%b (state,dc,e,mux1,wr_en,pc_load,pc_inc,p,halted,illegal,retired)",
                 mx.name, act, mx.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    inst = '0; jmp_flags = '0; mem_ready = 1'b1; run = 1'b0;
    @(posedge clk);
    #1;
    step("reset",    0, 'b001, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 0);
    rst_n = 1'b1;
    step("ldi_f",    0, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 0);
    step("ldi_e1",   0, 'b000, 1, 0, 'b010, 'b001, 'b000011, 0, 0, 0);
    step("add_f",    2, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 1);
    step("add_e1",   2, 'b000, 1, 0, 'b010, 'b110, 'b110010, 0, 0, 1);
    step("add_e2",   2, 'b000, 1, 0, 'b100, 'b111, 'b110000, 0, 0, 1);
    step("jeqt_f",   6, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 2);
    step("jeqt_e1",  6, 'b000, 1, 0, 'b010, 'b000, 'b010101, 0, 0, 2);
    step("jeqn_f",   6, 'b100, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 3);
    step("jeqn_e1",  6, 'b100, 1, 0, 'b010, 'b000, 'b000011, 0, 0, 3);
    step("sta_skip", 1, 'b001, 1, 0, 'b001, 'b000, 'b000100, 0, 0, 4);
    step("sta_e1",   1, 'b000, 1, 0, 'b010, 'b000, 'b011010, 0, 0, 4);
    step("lda_f",    8, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 5);
    step("lda_e1",   8, 'b000, 1, 0, 'b010, 'b000, 'b110011, 0, 0, 5);
    step("lda_e2",   8, 'b000, 1, 0, 'b100, 'b001, 'b100001, 0, 0, 5);
    step("sub_f",    3, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 6);
    step("sub_e1",   3, 'b000, 1, 0, 'b010, 'b010, 'b110010, 0, 0, 6);
`ifdef CTRL_SEQ_WAIT_EN
    for (int i = 0; i < 3; i++)
      step("sub_wait", 3, 'b000, 0, 0, 'b100, 'b010, 'b110000, 0, 0, 6);
    step("sub_e2",   3, 'b000, 1, 0, 'b100, 'b011, 'b110000, 0, 0, 6);
`else
    step("sub_e2",   3, 'b000, 0, 0, 'b100, 'b011, 'b110000, 0, 0, 6);
`endif
    step("jmi_f",    5, 'b010, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 7);
    step("jmi_e1",   5, 'b010, 1, 0, 'b010, 'b000, 'b010101, 0, 0, 7);
    step("jmp_f",    4, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 8);
    step("jmp_e1",   4, 'b000, 1, 0, 'b010, 'b000, 'b010101, 0, 0, 8);
    step("nop_f",    9, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 9);
    step("nop_e1",   9, 'b000, 1, 0, 'b010, 'b000, 'b000010, 0, 0, 9);
    step("ill_f",    'b010010, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 10);
    step("ill_e1",   'b010010, 'b000, 1, 0, 'b010, 'b000, 'b000010, 0, 0, 10);
    step("arm_f",    12, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 1, 11);
    step("arm_e1",   12, 'b000, 1, 0, 'b010, 'b000, 'b000010, 0, 1, 11);
    step("stp_f",    7, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 1, 12);
    step("stp_e1",   7, 'b000, 1, 0, 'b010, 'b000, 'b000000, 0, 1, 12);
    for (int i = 0; i < 5; i++)
      step("halt",   2, 'b001, 1, 0, 'b000, 'b000, 'b000000, 1, 1, 13);
    step("halt_run", 2, 'b001, 1, 1, 'b000, 'b000, 'b000000, 1, 1, 13);
    step("ldi2_f",   0, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 1, 13);
    step("ldi2_e1",  0, 'b000, 1, 0, 'b010, 'b001, 'b000011, 0, 1, 13);
    step("wrap_f",   9, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 1, 14);
    step("wrap_e1",  9, 'b000, 1, 0, 'b010, 'b000, 'b000010, 0, 1, 14);
    step("run_ign",  9, 'b000, 1, 1, 'b001, 'b000, 'b000000, 0, 1, 15);
    step("wrap_e1b", 9, 'b000, 1, 0, 'b010, 'b000, 'b000010, 0, 1, 15);
    step("wrap_zero",9, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 1, 0);
    step("wrap_e1c", 9, 'b000, 1, 0, 'b010, 'b000, 'b000010, 0, 1, 0);
    step("add3_f",   2, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 1, 1);
    step("add3_e1",  2, 'b000, 1, 0, 'b010, 'b110, 'b110010, 0, 1, 1);
    rst_n = 1'b0;
    #1;
    step("mid_rst",  2, 'b001, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 0);
    rst_n = 1'b1;
    step("post_f",   0, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 0);
    step("post_e1",  0, 'b000, 1, 0, 'b010, 'b001, 'b000011, 0, 0, 0);
    step("post_f2",  9, 'b000, 1, 0, 'b001, 'b000, 'b000000, 0, 0, 1);
    #20;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
